// File: rtl/vsd_arbiter.sv
// Round-robin arbiter from NUM virtual SD drives onto one hps_io block port; 1-cycle grant latency.
// A drive's request is held by hps_io's sd_ack handshake; cpu_wait stalls the CPU while writes are outstanding.
module vsd_arbiter #(
  parameter int NUM      = 2,
  parameter int LBA_W    = 32,
  parameter int DW       = 16,
  parameter int ACK_TO   = 28000000,
  parameter int ACT_HOLD = 1000000
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic [NUM*LBA_W-1:0] dev_lba,
  input  logic [NUM-1:0]       dev_rd,
  input  logic [NUM-1:0]       dev_wr,
  output logic [NUM-1:0]       dev_ack,
  input  logic [NUM*DW-1:0]    dev_buff_din,
  output logic [LBA_W-1:0]     sd_lba,
  output logic [NUM-1:0]       sd_rd,
  output logic [NUM-1:0]       sd_wr,
  input  logic [NUM-1:0]       sd_ack,
  output logic [DW-1:0]        sd_buff_din,
  output logic                 cpu_wait,
  output logic                 err,
  output logic                 act
);

  localparam int PW = (NUM > 1) ? $clog2(NUM) : 1;
  localparam int TW = $clog2(ACK_TO + 1);
  localparam int AW = $clog2(ACT_HOLD + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    BUSY     = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PW-1:0]      grant_q, grant_d;
  logic [PW-1:0]      rr_q, rr_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [AW-1:0]      act_cnt_q, act_cnt_d;
  logic [NUM-1:0]     sd_rd_q, sd_rd_d;
  logic [NUM-1:0]     sd_wr_q, sd_wr_d;
  logic [LBA_W-1:0]   sd_lba_q, sd_lba_d;
  logic               err_q, err_d;
  logic [NUM-1:0]     wpend_q, wpend_d;
  logic [NUM-1:0]     wr_prev_q;
  logic [NUM-1:0]     wclr;

  logic [NUM-1:0]     pend;
  logic               pick_vld;
  logic [PW-1:0]      pick_idx;
  logic [PW-1:0]      cand;

  logic [LBA_W-1:0]   lba_a [NUM];
  logic [DW-1:0]      din_a [NUM];

  function automatic logic [PW-1:0] inc_wrap(input logic [PW-1:0] v);
    return (v == PW'(NUM - 1)) ? '0 : v + PW'(1);
  endfunction

  for (genvar g = 0; g < NUM; g++) begin : g_lane
    assign lba_a[g]   = dev_lba[g*LBA_W +: LBA_W];
    assign din_a[g]   = dev_buff_din[g*DW +: DW];
    assign dev_ack[g] = sd_ack[g] & (grant_q == PW'(g)) & (state_q != IDLE);
  end

  assign pend = dev_rd | dev_wr;

  // Walk from rr_q around the ring; the first pending drive wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = rr_q;
    for (int k = 0; k < NUM; k++) begin
      if (!pick_vld && pend[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
      cand = inc_wrap(cand);
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    timer_d  = timer_q;
    sd_rd_d  = sd_rd_q;
    sd_wr_d  = sd_wr_q;
    sd_lba_d = sd_lba_q;
    err_d    = 1'b0;
    wclr     = '0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d  = pick_idx;
          sd_lba_d = lba_a[pick_idx];
          sd_rd_d  = '0;
          sd_wr_d  = '0;
          // A write takes precedence when the drive raises both.
          if (dev_wr[pick_idx]) sd_wr_d[pick_idx] = 1'b1;
          else                  sd_rd_d[pick_idx] = 1'b1;
          timer_d  = '0;
          state_d  = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (sd_ack[grant_q]) begin
          state_d = BUSY;
        end else if (timer_q == TW'(ACK_TO - 1)) begin
          sd_rd_d = '0;
          sd_wr_d = '0;
          err_d   = 1'b1;
          rr_d    = inc_wrap(grant_q);
          state_d = IDLE;
        end else if (timer_q != '1) begin
          timer_d = timer_q + TW'(1);
        end
      end
      BUSY: begin
        if (!sd_ack[grant_q]) begin
          wclr    = sd_wr_q;
          sd_rd_d = '0;
          sd_wr_d = '0;
          rr_d    = inc_wrap(grant_q);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new write edge wins over a completion clearing the same drive.
  assign wpend_d = (wpend_q & ~wclr) | (dev_wr & ~wr_prev_q);

  always_comb begin
    act_cnt_d = act_cnt_q;
    if (state_q == BUSY)     act_cnt_d = AW'(ACT_HOLD);
    else if (act_cnt_q != 0) act_cnt_d = act_cnt_q - AW'(1);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_q      <= '0;
      timer_q   <= '0;
      act_cnt_q <= '0;
      sd_rd_q   <= '0;
      sd_wr_q   <= '0;
      sd_lba_q  <= '0;
      err_q     <= 1'b0;
      wpend_q   <= '0;
      wr_prev_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      timer_q   <= timer_d;
      act_cnt_q <= act_cnt_d;
      sd_rd_q   <= sd_rd_d;
      sd_wr_q   <= sd_wr_d;
      sd_lba_q  <= sd_lba_d;
      err_q     <= err_d;
      wpend_q   <= wpend_d;
      wr_prev_q <= dev_wr;
    end
  end

  assign sd_rd       = sd_rd_q;
  assign sd_wr       = sd_wr_q;
  assign sd_lba      = sd_lba_q;
  assign err         = err_q;
  assign cpu_wait    = |wpend_q;
  assign act         = (act_cnt_q != 0);
  assign sd_buff_din = din_a[grant_q];

endmodule

// File: tb/tb_vsd_arbiter.sv
// Bench for vsd_arbiter: directed scenarios plus randomized drives/hps_io, all checked against a cycle model.
module tb_vsd_arbiter;
  localparam int NUM      = 3;
  localparam int LBA_W    = 32;
  localparam int DW       = 16;
  localparam int ACK_TO   = 16;
  localparam int ACT_HOLD = 20;

  logic                 clk_sys = 1'b0;
  logic                 reset_n;
  logic [NUM*LBA_W-1:0] dev_lba;
  logic [NUM-1:0]       dev_rd, dev_wr, dev_ack;
  logic [NUM*DW-1:0]    dev_buff_din;
  logic [LBA_W-1:0]     sd_lba;
  logic [NUM-1:0]       sd_rd, sd_wr, sd_ack;
  logic [DW-1:0]        sd_buff_din;
  logic                 cpu_wait, err, act;

  always #5 clk_sys = ~clk_sys;

  vsd_arbiter #(.NUM(NUM), .LBA_W(LBA_W), .DW(DW), .ACK_TO(ACK_TO), .ACT_HOLD(ACT_HOLD)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .dev_lba(dev_lba), .dev_rd(dev_rd), .dev_wr(dev_wr),
    .dev_ack(dev_ack), .dev_buff_din(dev_buff_din), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_ack(sd_ack), .sd_buff_din(sd_buff_din), .cpu_wait(cpu_wait), .err(err), .act(act)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: owner = drive currently holding the port (-1 when free).
  int               m_owner, m_grant, m_rr, m_timer, m_act_cnt;
  bit               m_acked, m_err;
  logic [NUM-1:0]   m_sd_rd, m_sd_wr, m_wpend, m_prev_wr;
  logic [LBA_W-1:0] m_lba;

  task automatic model_reset();
    m_owner = -1; m_grant = 0; m_rr = 0; m_timer = 0; m_act_cnt = 0;
    m_acked = 0; m_err = 0; m_sd_rd = '0; m_sd_wr = '0; m_wpend = '0;
    m_prev_wr = '0; m_lba = '0;
  endtask

  function automatic int first_bit(input logic [NUM-1:0] v);
    for (int i = 0; i < NUM; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int rr_pick(input logic [NUM-1:0] pend, input int start);
    for (int k = 0; k < NUM; k++) if (pend[(start + k) % NUM]) return (start + k) % NUM;
    return -1;
  endfunction

  task automatic model_step();
    logic [NUM-1:0] pend, clr;
    bit busy_now;
    int i;
    if (!reset_n) begin
      model_reset();
      return;
    end
    pend = dev_rd | dev_wr;
    clr = '0;
    busy_now = (m_owner >= 0) && m_acked;
    m_err = 0;
    if (m_owner < 0) begin
      i = rr_pick(pend, m_rr);
      if (i >= 0) begin
        m_owner = i; m_grant = i; m_acked = 0; m_timer = 0;
        m_lba = dev_lba[i*LBA_W +: LBA_W];
        m_sd_rd = '0; m_sd_wr = '0;
        if (dev_wr[i]) m_sd_wr[i] = 1'b1; else m_sd_rd[i] = 1'b1;
      end
    end else if (!m_acked) begin
      if (sd_ack[m_owner]) m_acked = 1;
      else if (m_timer == ACK_TO - 1) begin
        m_sd_rd = '0; m_sd_wr = '0; m_err = 1;
        m_rr = (m_owner + 1) % NUM; m_owner = -1;
      end else m_timer++;
    end else if (!sd_ack[m_owner]) begin
      if (m_sd_wr[m_owner]) clr[m_owner] = 1'b1;
      m_sd_rd = '0; m_sd_wr = '0;
      m_rr = (m_owner + 1) % NUM; m_owner = -1;
    end
    m_act_cnt = busy_now ? ACT_HOLD : ((m_act_cnt > 0) ? m_act_cnt - 1 : 0);
    m_wpend = (m_wpend & ~clr) | (dev_wr & ~m_prev_wr);
    m_prev_wr = dev_wr;
  endtask

  task automatic check_outputs();
    logic [NUM-1:0] e_ack;
    for (int k = 0; k < NUM; k++) e_ack[k] = sd_ack[k] && (m_owner == k);
    chk("sd_rd", sd_rd, m_sd_rd);
    chk("sd_wr", sd_wr, m_sd_wr);
    chk("sd_lba", sd_lba, m_lba);
    chk("cpu_wait", cpu_wait, |m_wpend);
    chk("err", err, m_err);
    chk("act", act, m_act_cnt != 0);
    chk("dev_ack", dev_ack, e_ack);
    chk("sd_buff_din", sd_buff_din, dev_buff_din[m_grant*DW +: DW]);
    chk("onehot", $countones(sd_rd | sd_wr) <= 1, 1);
  endtask

  task automatic step();
    @(posedge clk_sys);
    model_step();
    #2;
    check_outputs();
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    dev_rd = '0; dev_wr = '0; sd_ack = '0; dev_lba = '0; dev_buff_din = '0;
    #1;
    model_reset();
    check_outputs();
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic serve(output int idx, input int dly, input int len);
    int n;
    idx = -1;
    n = 0;
    while ((sd_rd | sd_wr) == 0 && n < 50) begin
      step();
      n++;
    end
    chk("serve_grant", (sd_rd | sd_wr) != 0, 1);
    if ((sd_rd | sd_wr) == 0) return;
    idx = first_bit(sd_rd | sd_wr);
    repeat (dly) step();
    sd_ack[idx] = 1'b1;
    repeat (len) step();
    sd_ack[idx] = 1'b0;
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  int idx, err_cnt, err_at, n;
  int h_st, h_cnt, h_idx;
  logic [NUM-1:0] h_ack, sp, req;
  int order [4] = '{0, 1, 0, 1};

  initial begin
    reset_n = 1'b0;
    dev_rd = '0; dev_wr = '0; sd_ack = '0; dev_lba = '0; dev_buff_din = '0;
    model_reset();
    #12;
    check_outputs();
    #5 reset_n = 1'b1;

    // Single read on drive 0, long ack.
    dev_rd[0] = 1'b1; dev_lba[31:0] = 32'h100;
    step();
    chk("d1_rd", sd_rd, 3'b001);
    chk("d1_lba", sd_lba, 32'h100);
    repeat (3) step();
    sd_ack[0] = 1'b1;
    step();
    dev_rd[0] = 1'b0;
    chk("d1_ack", dev_ack, 3'b001);
    repeat (255) step();
    sd_ack[0] = 1'b0;
    step();
    chk("d1_drop", sd_rd, 3'b000);

    // Two drives held: grants alternate.
    apply_reset();
    dev_rd[0] = 1'b1; dev_rd[1] = 1'b1;
    dev_lba[31:0] = 32'hA0; dev_lba[63:32] = 32'hB1;
    for (int k = 0; k < 4; k++) begin
      serve(idx, 1, 2);
      chk("d2_order", idx, order[k]);
    end
    dev_rd = '0;

    // Write on drive 1 holds cpu_wait until the ack falls.
    apply_reset();
    dev_wr[1] = 1'b1; dev_buff_din[16 +: 16] = 16'hBEEF;
    step();
    chk("d3_wait_rise", cpu_wait, 1);
    chk("d3_wr", sd_wr, 3'b010);
    repeat (2) step();
    sd_ack[1] = 1'b1;
    step();
    chk("d3_busy_wait", cpu_wait, 1);
    chk("d3_din", sd_buff_din, 16'hBEEF);
    dev_wr[1] = 1'b0;
    repeat (3) step();
    sd_ack[1] = 1'b0;
    step();
    chk("d3_wait_clr", cpu_wait, 0);
    chk("d3_wr_drop", sd_wr, 3'b000);

    // Ack timeout and retry.
    apply_reset();
    dev_rd[0] = 1'b1;
    err_cnt = 0; err_at = -1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (err) begin
        err_cnt++;
        err_at = k;
      end
      if (k == 16) chk("d4_rd_dropped", sd_rd, 3'b000);
      if (k == 17) chk("d4_regrant", sd_rd, 3'b001);
    end
    chk("d4_err_count", err_cnt, 1);
    chk("d4_err_cycle", err_at, 16);

    // Spurious ack on a non-granted drive.
    apply_reset();
    dev_rd[0] = 1'b1;
    step();
    sd_ack[1] = 1'b1;
    step();
    chk("d5_spur_ack", dev_ack[1], 0);
    chk("d5_still_wait", sd_rd, 3'b001);
    sd_ack[1] = 1'b0;

    // Reset during BUSY.
    apply_reset();
    dev_rd[0] = 1'b1;
    step();
    sd_ack[0] = 1'b1;
    repeat (2) step();
    dev_rd[0] = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    model_reset();
    chk("d6_async_rd", sd_rd, 3'b000);
    chk("d6_async_ack", dev_ack, 3'b000);
    chk("d6_async_act", act, 0);
    check_outputs();
    repeat (2) step();
    reset_n = 1'b1;
    step();
    chk("d6_ack_ignored", dev_ack, 3'b000);
    chk("d6_idle", sd_rd | sd_wr, 3'b000);
    sd_ack = '0;

    // Randomized drives and hps_io responder.
    apply_reset();
    h_st = 0; h_cnt = 0; h_idx = 0; h_ack = '0; sp = '0;
    for (n = 0; n < 3000; n++) begin
      step();
      req = sd_rd | sd_wr;
      for (int i = 0; i < NUM; i++) begin
        dev_buff_din[i*DW +: DW] = 16'($urandom);
        if (dev_ack[i]) begin
          dev_rd[i] = 1'b0; dev_wr[i] = 1'b0;
        end else if (!dev_rd[i] && !dev_wr[i] && $urandom_range(0, 7) == 0) begin
          idx = $urandom_range(0, 2);
          dev_rd[i] = (idx != 1);
          dev_wr[i] = (idx != 0);
          dev_lba[i*LBA_W +: LBA_W] = $urandom;
        end else if ((dev_rd[i] || dev_wr[i]) && $urandom_range(0, 63) == 0) begin
          dev_rd[i] = 1'b0; dev_wr[i] = 1'b0;
        end
      end
      case (h_st)
        0: if (req != 0) begin
             h_idx = first_bit(req);
             h_cnt = ($urandom_range(0, 7) == 0) ? 40 : $urandom_range(0, 4);
             h_st = 1;
           end
        1: if (req == 0) h_st = 0;
           else if (h_cnt == 0) begin
             h_ack[h_idx] = 1'b1;
             h_cnt = $urandom_range(1, 6);
             h_st = 2;
           end else h_cnt--;
        2: begin
             h_cnt--;
             if (h_cnt == 0) begin
               h_ack[h_idx] = 1'b0;
               h_st = 3;
             end
           end
        default: if (req == 0) h_st = 0;
      endcase
      sp = '0;
      for (int j = 0; j < NUM; j++)
        if (!req[j] && !(h_st != 0 && h_idx == j) && $urandom_range(0, 15) == 0) sp[j] = 1'b1;
      sd_ack = h_ack | sp;
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/vsd_arbiter.md
Name: vsd_arbiter

Overview:
- Parametrised N-drive virtual SD request arbiter. It sits between NUM sd_card instances and the single hps_io block-device interface.
- It replaces the ad-hoc two-drive LBA/buffer muxing and write-wait logic in the top level.
- It serialises drive requests with round-robin fairness and holds the CPU while a write is in flight.
- It guards against a non-responding HPS with an ack timeout, and drives an activity LED output.

Parameters:
- NUM, 2, number of virtual drives (1..8).
- LBA_W, 32, LBA width.
- DW, 16, sector buffer data width (WIDE=1 → 16).
- ACK_TO, 28000000, clk_sys cycles allowed from grant to first sd_ack before the request is aborted.
- ACT_HOLD, 1000000, clk_sys cycles the activity LED stays on after the last transfer.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- dev_lba  in  NUM*LBA_W  per-drive LBA; drive i occupies [i*LBA_W +: LBA_W].
- dev_rd  in  NUM  per-drive read request, level.
- dev_wr  in  NUM  per-drive write request, level.
- dev_ack  out  NUM  per-drive ack.
- dev_buff_din  in  NUM*DW  per-drive write data.
- sd_lba  out  LBA_W  LBA to hps_io.
- sd_rd  out  NUM  read request to hps_io, at most one bit set.
- sd_wr  out  NUM  write request to hps_io, at most one bit set.
- sd_ack  in  NUM  ack from hps_io.
- sd_buff_din  out  DW  write data to hps_io.
- cpu_wait  out  1  high while any write is pending or in service.
- err  out  1  one-cycle pulse on ack timeout.
- act  out  1  activity LED.

Behaviour:
- Reset (async, reset_n=0): state=IDLE, grant=0, rr_ptr=0, sd_rd=0, sd_wr=0, sd_lba=0, cpu_wait=0, err=0, act=0, timers=0. Reset mid-transfer drops sd_rd/sd_wr immediately. Any later sd_ack is ignored and not forwarded.
- pend[i] = dev_rd[i] | dev_wr[i].
- IDLE: if any pend, pick the first pending index at or after rr_ptr, wrapping modulo NUM.
  - Next cycle: grant=i; sd_lba=dev_lba[i]; sd_rd[i]=dev_rd[i], sd_wr[i]=dev_wr[i] (both registered, so 1-cycle latency); state→WAIT_ACK; timer cleared.
  - Write wins if dev_rd[i] and dev_wr[i] are both set.
- WAIT_ACK: sd_rd/sd_wr held. timer increments each cycle.
  - sd_ack[grant]=1 → state BUSY.
  - timer==ACK_TO-1 → clear sd_rd/sd_wr, pulse err for 1 cycle, rr_ptr=grant+1 (mod NUM), state IDLE. The request stays pending at the drive and is retried on its next turn.
- BUSY: sd_rd/sd_wr held while sd_ack[grant]=1.
  - On sd_ack[grant] falling: clear sd_rd/sd_wr, rr_ptr=grant+1 (mod NUM), state IDLE.
  - A new grant may issue no earlier than 1 cycle after the fall.
- Combinational paths:
  - dev_ack[i] = sd_ack[i] & (i==grant) & (state!=IDLE). Acks on non-granted bits are ignored.
  - sd_buff_din = dev_buff_din[grant] in all states. It must be valid in the same cycle as sd_ack, because buffer data is addressed by hps_io.
- cpu_wait:
  - wpend[i] is set on a dev_wr[i] rising edge.
  - wpend[i] is cleared when the BUSY→IDLE transition completes for grant==i with sd_wr set.
  - cpu_wait = |wpend. A timeout does not clear wpend.
- act: set to 1 and counter reloaded to ACT_HOLD whenever state==BUSY. The counter decrements otherwise; act=0 when it reaches 0.
- Arithmetic: rr_ptr and grant are $clog2(NUM) bits (min 1); wrap to 0 after NUM-1. Timers saturate and never wrap.
- Simultaneous events:
  - A request deasserted by the drive while in WAIT_ACK is still carried to ack or timeout.
  - dev_rd rising on another drive during BUSY waits for IDLE.
  - NUM=1 degenerates to a pass-through with 1-cycle request latency.

Test Plan:
- NUM=2, dev_rd[0]=1 lba 0x100 → cycle+1: sd_rd=2'b01, sd_lba=0x100. sd_ack[0] high 256 cycles then low → dev_ack[0] mirrors it; sd_rd=0 one cycle after the fall.
- dev_rd[0] and dev_rd[1] asserted together, held → grant order 0,1,0,1. sd_lba alternates between drives. sd_rd never has two bits set.
- dev_wr[1]=1 with dev_buff_din[1]=0xBEEF → cpu_wait=1 from the cycle after the rise until BUSY ends; sd_buff_din=0xBEEF during ack; cpu_wait=0 one cycle after sd_ack[1] falls.
- ACK_TO=16, dev_rd[0]=1, no sd_ack → err pulses exactly once at cycle 16 after grant; sd_rd drops; request re-granted after the round-robin pass.
- Spurious sd_ack[1]=1 while drive 0 is granted → dev_ack[1]=0, state unchanged.
- reset_n low mid-BUSY → all outputs 0 asynchronously; after release with sd_ack still high, dev_ack=0 and state IDLE.
